ila_verdict_monitor: RTL and testbench

- Consumes the `ok` flags of the register-file checker (`ila_rm`) and the data-memory checker (`ila_dm`), and turns them into a single latched test verdict.
- Arms on a start pulse and counts cycles and retired instructions until the core signals halt.
- After halt, requires both flags to be stable-high for a settle window, then reports PASS or FAIL.
- Reports TIMEOUT if halt never arrives. Drives board LEDs and the testbench end-of-test detection.

---
 rtl/ila_verdict_monitor_pkg.sv | 22 ++
 rtl/ila_verdict_monitor_sat_counter.sv | 14 +
 rtl/ila_verdict_monitor.sv | 83 ++++++++
 tb/tb_ila_verdict_monitor.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/ila_verdict_monitor_pkg.sv
// ila_verdict_monitor_pkg: verdict/state types and fail_mask bit positions shared by the ILA verdict monitor.
package ila_verdict_monitor_pkg;
  typedef enum logic [1:0] {
    V_NONE    = 2'd0,
    V_PASS    = 2'd1,
    V_FAIL    = 2'd2,
    V_TIMEOUT = 2'd3
  } ila_verdict_e;
  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_SETTLE,
    S_PASS,
    S_FAIL,
    S_TIMEOUT
  } ila_mon_state_e;
  localparam int FM_RM_BIT = 0;
  localparam int FM_DM_BIT = 1;
  function automatic ila_verdict_e state_verdict(input ila_mon_state_e s);
    return s == S_PASS ? V_PASS : s == S_FAIL ? V_FAIL : s == S_TIMEOUT ? V_TIMEOUT : V_NONE;
  endfunction
endpackage

// File: rtl/ila_verdict_monitor_sat_counter.sv
// ila_sat_counter: W-bit up counter with synchronous clear that sticks at all-ones.
module ila_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);
  always_ff @(posedge clk)
    if (rst || clr) count <= '0;
    else if (en && count != '1) count <= count + W'(1);
endmodule

// File: rtl/ila_verdict_monitor.sv
// ila_verdict_monitor: arms on start, counts RUN cycles/retires until halt, then latches PASS/FAIL/TIMEOUT
// from rm_ok/dm_ok sampled over a settle window.
module ila_verdict_monitor
  import ila_verdict_monitor_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt,
  input  logic             retire,
  input  logic             rm_ok,
  input  logic             dm_ok,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [1:0]       verdict,
  output logic [1:0]       fail_mask,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retire_count
);
  localparam int SW = SETTLE_CYCLES < 2 ? 1 : $clog2(SETTLE_CYCLES);
  if (TIMEOUT_CYCLES < 1 || (CNT_W < 32 && 64'(TIMEOUT_CYCLES) >= (64'd1 << CNT_W))) begin : g_bad_timeout
    $error("ila_verdict_monitor: TIMEOUT_CYCLES out of range 1 .. 2^CNT_W-1");
  end
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("ila_verdict_monitor: SETTLE_CYCLES must be >= 1");
  end
  ila_mon_state_e state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [1:0] mask_s, mask_d;
  logic arm, run, settle_end;
  // start only re-arms from IDLE or a terminal verdict; RUN/SETTLE ignore it
  assign arm = start && !(state_q inside {S_RUN, S_SETTLE});
  assign run = state_q == S_RUN;
  always_comb begin
    mask_s = fail_mask;
    mask_s[FM_RM_BIT] = fail_mask[FM_RM_BIT] | ~rm_ok;
    mask_s[FM_DM_BIT] = fail_mask[FM_DM_BIT] | ~dm_ok;
    settle_end = settle_q == SW'(SETTLE_CYCLES - 1);
    settle_d = state_q == S_SETTLE ? settle_q + SW'(1) : '0;
    mask_d = arm ? 2'b00 : state_q == S_SETTLE ? mask_s : fail_mask;
    state_d = arm ? S_RUN
      : run ? (halt ? S_SETTLE : cycle_count == CNT_W'(TIMEOUT_CYCLES - 1) ? S_TIMEOUT : S_RUN)
      : state_q == S_SETTLE ? (!settle_end ? S_SETTLE : mask_s == 2'b00 ? S_PASS : S_FAIL)
      : state_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q   <= S_IDLE;
      settle_q  <= '0;
      fail_mask <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      verdict   <= V_NONE;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      fail_mask <= mask_d;
      done      <= state_d inside {S_PASS, S_FAIL, S_TIMEOUT};
      pass      <= state_d == S_PASS;
      fail      <= state_d inside {S_FAIL, S_TIMEOUT};
      verdict   <= state_verdict(state_d);
    end
  ila_sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (arm),
    .en    (run),
    .count (cycle_count)
  );
  ila_sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (arm),
    .en    (run && retire),
    .count (retire_count)
  );
endmodule

// File: tb/tb_ila_verdict_monitor.sv
// tb_ila_verdict_monitor: randomized scenarios against a run-level outcome model, checked by a scoreboard monitor.
module tb_ila_verdict_monitor;
  localparam int TO = 20;
  localparam int ST = 4;
  typedef struct {
    int verdict;
    int mask;
    int cyc;
    int ret;
    int edge_at;
  } exp_t;
  logic clk, rst, start, halt, retire, rm_ok, dm_ok;
  logic done, pass, fail;
  logic [1:0] verdict, fail_mask;
  logic [31:0] cycle_count, retire_count;
  int tests = 0;
  int failed = 0;
  int edge_n = 0;
  exp_t sb[$];
  ila_verdict_monitor #(.TIMEOUT_CYCLES(TO), .SETTLE_CYCLES(ST), .CNT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .halt         (halt),
    .retire       (retire),
    .rm_ok        (rm_ok),
    .dm_ok        (dm_ok),
    .done         (done),
    .pass         (pass),
    .fail         (fail),
    .verdict      (verdict),
    .fail_mask    (fail_mask),
    .cycle_count  (cycle_count),
    .retire_count (retire_count)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial forever begin
    @(posedge clk);
    edge_n++;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end
  function automatic void chk(input string name, input longint unsigned act, input longint unsigned exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction
  task automatic check_zero(input string tag);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_fail"}, fail, 0);
    chk({tag, "_verdict"}, verdict, 0);
    chk({tag, "_mask"}, fail_mask, 0);
    chk({tag, "_cyc"}, cycle_count, 0);
    chk({tag, "_ret"}, retire_count, 0);
  endtask
  // monitor: pops on done rising, checks hold while done, checks clear when done falls
  initial begin
    exp_t e, cap;
    bit prev_done = 0;
    cap = '{0, 0, 0, 0, 0};
    forever begin
      @(posedge clk);
      #1;
      if (done === 1'b1 && !prev_done) begin
        if (sb.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = sb.pop_front();
          chk("done_edge", edge_n, e.edge_at);
          chk("verdict", verdict, e.verdict);
          chk("pass", pass, e.verdict == 1);
          chk("fail", fail, e.verdict >= 2);
          chk("fail_mask", fail_mask, e.mask);
          chk("cycle_count", cycle_count, e.cyc);
          chk("retire_count", retire_count, e.ret);
          cap = e;
        end
      end else if (done === 1'b1) begin
        chk("hold_verdict", verdict, cap.verdict);
        chk("hold_mask", fail_mask, cap.mask);
        chk("hold_cyc", cycle_count, cap.cyc);
        chk("hold_ret", retire_count, cap.ret);
      end else if (prev_done) begin
        check_zero("rearm");
      end
      prev_done = done === 1'b1;
    end
  end
  // mode 0: random; 1: clean (ok flags high, 7 retires); 2: dm_ok low in settle cycle 3; 3: reset at settle cycle 2
  task automatic run_test(input int h, input int mode);
    exp_t e;
    int rets, es, n;
    logic [1:0] m;
    bit aborted;
    rets = 0;
    m = 2'b00;
    aborted = 0;
    @(negedge clk);
    start = 1;
    halt = 0;
    retire = 1'($urandom);
    rm_ok = 1'($urandom);
    dm_ok = 1'($urandom);
    es = edge_n + 1;
    n = h <= TO ? h : TO;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      start = mode == 0 && $urandom_range(0, 5) == 0;
      retire = mode == 0 ? 1'($urandom) : 1'(i <= 7);
      halt = i == h;
      rm_ok = mode == 0 ? 1'($urandom) : 1'b1;
      dm_ok = mode == 0 ? 1'($urandom) : 1'b1;
      rets += int'(retire);
    end
    if (h <= TO) begin
      for (int j = 1; j <= ST && !aborted; j++) begin
        @(negedge clk);
        start = mode == 0 && $urandom_range(0, 5) == 0;
        retire = 1'($urandom);
        halt = 1'($urandom);
        rm_ok = mode == 0 ? 1'($urandom_range(0, 7) != 0) : 1'b1;
        dm_ok = mode == 0 ? 1'($urandom_range(0, 7) != 0) : mode == 2 ? 1'(j != 3) : 1'b1;
        m[0] = m[0] | ~rm_ok;
        m[1] = m[1] | ~dm_ok;
        if (mode == 3 && j == 2) begin
          rst = 1;
          @(negedge clk);
          check_zero("rst_mid_settle");
          rst = 0;
          aborted = 1;
        end
      end
    end
    if (!aborted) begin
      e = h <= TO ? '{m == 0 ? 1 : 2, int'(m), h, rets, es + h + ST} : '{3, 0, TO, rets, es + TO};
      sb.push_back(e);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start = 0;
      retire = 1'($urandom);
      halt = 1'($urandom);
      rm_ok = 1'($urandom);
      dm_ok = 1'($urandom);
    end
  endtask
  initial begin
    rst = 1;
    start = 0;
    halt = 0;
    retire = 0;
    rm_ok = 1;
    dm_ok = 1;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 0;
    run_test(10, 1);
    run_test(6, 2);
    run_test(25, 0);
    run_test(20, 1);
    run_test(5, 3);
    run_test(8, 1);
    for (int k = 0; k < 14; k++) run_test($urandom_range(1, 24), 0);
    repeat (6) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
